// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: one-hot grant tenures separated by a single dead cycle.
// Optional tenure time-out is built when WRR_TIMEOUT_EN is defined.
module wrr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned WEIGHT_W = 4,
    parameter int unsigned QUANTUM  = 8
) (
    input  logic                    i_clk,
    input  logic                    i_sclr,
    input  logic [N-1:0]            i_req,
    input  logic                    i_done,
    input  logic                    i_cfg_we,
    input  logic [$clog2(N)-1:0]    i_cfg_idx,
    input  logic [WEIGHT_W-1:0]     i_cfg_weight,
    output logic [N-1:0]            o_grant,
    output logic                    o_grant_vld,
    output logic [$clog2(N)-1:0]    o_grant_id,
    output logic                    o_timeout
);

    localparam int unsigned IDX_W = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WEIGHT_W-1:0]   r_weight [N];
    logic [IDX_W-1:0]      r_ptr, w_ptr_nxt;
    logic [WEIGHT_W-1:0]   r_credit, w_credit_nxt;
    logic [N-1:0]          r_grant, w_grant_nxt;
    logic                  r_grant_vld, w_grant_vld_nxt;
    logic [IDX_W-1:0]      r_grant_id, w_grant_id_nxt;
    logic                  r_timeout, w_timeout_nxt;

    logic [N-1:0]          w_elig;
    logic                  w_sel_hit;
    logic [IDX_W-1:0]      w_sel_idx;
    logic [WEIGHT_W-1:0]   w_sel_credit;
    logic                  w_quantum_hit;
    logic                  w_end;
    logic                  w_to_end;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= N) s = s - N;
        return IDX_W'(s);
    endfunction

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_elig[i] = i_req[i] && (r_weight[i] != '0);
        end
    end

    // Re-grant the last owner while it has credit, else the first eligible index after it.
    always_comb begin
        w_sel_hit    = 1'b0;
        w_sel_idx    = r_ptr;
        w_sel_credit = '0;
        if (w_elig[r_ptr] && (r_credit != '0)) begin
            w_sel_hit    = 1'b1;
            w_sel_credit = r_credit - 1'b1;
        end else begin
            // Descending scan so the nearest index after PTR wins.
            for (int k = int'(N); k >= 1; k--) begin
                if (w_elig[wrap_add(r_ptr, k)]) begin
                    w_sel_hit    = 1'b1;
                    w_sel_idx    = wrap_add(r_ptr, k);
                    w_sel_credit = r_weight[wrap_add(r_ptr, k)] - 1'b1;
                end
            end
        end
    end

`ifdef WRR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(QUANTUM + 1);

    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

    assign w_quantum_hit = (r_cnt == CNT_W'(QUANTUM));

    // Counter reads 1 in the first owned cycle.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (r_state != S_OWN) begin
            w_cnt_nxt = CNT_W'(1);
        end else if (!w_end) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    assign w_quantum_hit = 1'b0;
`endif

    assign w_end    = i_done || !i_req[r_ptr] || w_quantum_hit;
    // A release that coincides with the quantum is reported as a release.
    assign w_to_end = w_quantum_hit && !i_done && i_req[r_ptr];

    always_comb begin
        w_state_nxt     = r_state;
        w_ptr_nxt       = r_ptr;
        w_credit_nxt    = r_credit;
        w_grant_nxt     = r_grant;
        w_grant_vld_nxt = r_grant_vld;
        w_grant_id_nxt  = r_grant_id;
        w_timeout_nxt   = 1'b0;
        case (r_state)
            S_IDLE, S_GAP: begin
                if (w_sel_hit) begin
                    w_state_nxt     = S_OWN;
                    w_ptr_nxt       = w_sel_idx;
                    w_credit_nxt    = w_sel_credit;
                    w_grant_nxt     = N'(1) << w_sel_idx;
                    w_grant_vld_nxt = 1'b1;
                    w_grant_id_nxt  = w_sel_idx;
                end else begin
                    w_state_nxt     = S_IDLE;
                    w_grant_nxt     = '0;
                    w_grant_vld_nxt = 1'b0;
                    w_grant_id_nxt  = '0;
                end
            end
            S_OWN: begin
                if (w_end) begin
                    w_state_nxt     = S_GAP;
                    w_grant_nxt     = '0;
                    w_grant_vld_nxt = 1'b0;
                    w_grant_id_nxt  = '0;
                    w_timeout_nxt   = w_to_end;
                end
            end
            default: begin
                w_state_nxt     = S_IDLE;
                w_grant_nxt     = '0;
                w_grant_vld_nxt = 1'b0;
                w_grant_id_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_sclr) begin
            r_state     <= S_IDLE;
            r_ptr       <= IDX_W'(N - 1);
            r_credit    <= '0;
            r_grant     <= '0;
            r_grant_vld <= 1'b0;
            r_grant_id  <= '0;
            r_timeout   <= 1'b0;
            for (int i = 0; i < int'(N); i++) begin
                r_weight[i] <= WEIGHT_W'(1);
            end
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_credit    <= w_credit_nxt;
            r_grant     <= w_grant_nxt;
            r_grant_vld <= w_grant_vld_nxt;
            r_grant_id  <= w_grant_id_nxt;
            r_timeout   <= w_timeout_nxt;
            if (i_cfg_we && (32'(i_cfg_idx) < N)) begin
                r_weight[i_cfg_idx] <= i_cfg_weight;
            end
        end
    end

    assign o_grant     = r_grant;
    assign o_grant_vld = r_grant_vld;
    assign o_grant_id  = r_grant_id;
    assign o_timeout   = r_timeout;

endmodule
